// File: rtl/led_mmio_pkg.sv
// Shared definitions for the LED/blink MMIO peripheral: register offsets,
// CTRL bit positions, bus FSM states and a byte-strobe merge helper.
package led_mmio_pkg;

  localparam logic [3:0] LED_CTRL_OFS   = 4'h0;
  localparam logic [3:0] LED_PERIOD_OFS = 4'h4;
  localparam logic [3:0] LED_STATUS_OFS = 4'h8;
  localparam logic [3:0] LED_DIRECT_OFS = 4'hC;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_t;

  // Replace only the bytes whose strobe is set; the others keep old_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Blink timebase: counts cycles up to max(period,1)-1, emits a one-cycle
// tick at the terminal count and keeps a 16-bit wrapping tick counter.
module led_blink_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic             clr_cnt,
  input  logic             clr_toggles,
  output logic             tick,
  output logic [15:0]      toggle_cnt
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] term;

  // PERIOD=0 behaves like PERIOD=1: terminal count 0, tick every cycle.
  assign term = (period == '0) ? '0 : period - 1'b1;

  // A counter restart (register write) swallows any tick due this cycle.
  assign tick = en && !clr_cnt && (count_reg == term);

  // Cycle counter: held at 0 when disabled, restarted on clear or terminal.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (!en || clr_cnt || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Tick counter: a clear beats a simultaneous tick; wraps 0xFFFF -> 0.
  always_ff @(posedge clk) begin
    if (srst) begin
      toggle_cnt <= '0;
    end else if (clr_toggles) begin
      toggle_cnt <= '0;
    end else if (tick) begin
      toggle_cnt <= toggle_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/led_mmio_slave.sv
// Memory-mapped LED peripheral: two-state bus responder (accept, then a
// one-cycle response), a small register file and the LED output driver.
module led_mmio_slave
  import led_mmio_pkg::*;
#(
  parameter int          ADDR_W         = 4,
  parameter int unsigned DEFAULT_PERIOD = 25_000_000,
  parameter int          CNT_W          = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              bus_valid,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [3:0]        bus_wstrb,
  input  logic [31:0]       bus_wdata,
  output logic              bus_ready,
  output logic [31:0]       bus_rdata,
  output logic              bus_err,
  output logic              led_test
);

  bus_state_t       state_reg;
  logic [1:0]       ctrl_reg;
  logic [CNT_W-1:0] period_reg;
  logic             direct_reg;
  logic [15:0]      toggle_cnt;
  logic             tick;

  logic [3:0]       word_ofs;
  logic             addr_ok;
  logic             accept;
  logic             wr_en;
  logic             wr_ctrl;
  logic             wr_period;
  logic             wr_status;
  logic             wr_direct;
  logic [31:0]      period_merged;
  logic [31:0]      rd_mux;
  logic             blink_en;

  assign word_ofs  = {bus_addr[3:2], 2'b00};
  // Word-aligned and inside the 16-byte window (upper bits only exist if ADDR_W>4).
  assign addr_ok   = (bus_addr[1:0] == 2'b00) && ((bus_addr >> 4) == '0);
  assign accept    = (state_reg == IDLE) && bus_valid;
  assign wr_en     = accept && addr_ok && (bus_wstrb != 4'b0000);
  assign wr_ctrl   = wr_en && (word_ofs == LED_CTRL_OFS);
  assign wr_period = wr_en && (word_ofs == LED_PERIOD_OFS);
  assign wr_status = wr_en && (word_ofs == LED_STATUS_OFS);
  assign wr_direct = wr_en && (word_ofs == LED_DIRECT_OFS);

  assign period_merged = merge_bytes(32'(period_reg), bus_wdata, bus_wstrb);
  assign blink_en      = ctrl_reg[CTRL_EN_BIT] && ctrl_reg[CTRL_MODE_BIT];

  // Read mux over the pre-edge register values.
  always_comb begin
    rd_mux = 32'd0;
    case (word_ofs)
      LED_CTRL_OFS:   rd_mux = {30'd0, ctrl_reg};
      LED_PERIOD_OFS: rd_mux = 32'(period_reg);
      LED_STATUS_OFS: rd_mux = {toggle_cnt, 15'd0, led_test};
      LED_DIRECT_OFS: rd_mux = {31'd0, direct_reg};
      default:        rd_mux = 32'd0;
    endcase
  end

  // Bus FSM with registered response: accept in IDLE, respond in RESP.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= IDLE;
      bus_ready <= 1'b0;
      bus_rdata <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          bus_ready <= 1'b0;
          bus_rdata <= 32'd0;
          bus_err   <= 1'b0;
          if (bus_valid) begin
            state_reg <= RESP;
            bus_ready <= 1'b1;
            bus_err   <= !addr_ok;
            bus_rdata <= (addr_ok && bus_wstrb == 4'b0000) ? rd_mux : 32'd0;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          bus_ready <= 1'b0;
          bus_rdata <= 32'd0;
          bus_err   <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          bus_ready <= 1'b0;
          bus_rdata <= 32'd0;
          bus_err   <= 1'b0;
        end
      endcase
    end
  end

  // Register file writes; CTRL and DIRECT live entirely in byte 0.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ctrl_reg   <= 2'b00;
      period_reg <= CNT_W'(DEFAULT_PERIOD);
      direct_reg <= 1'b0;
    end else begin
      if (wr_ctrl && bus_wstrb[0]) ctrl_reg <= bus_wdata[1:0];
      if (wr_period) period_reg <= period_merged[CNT_W-1:0];
      if (wr_direct && bus_wstrb[0]) direct_reg <= bus_wdata[0];
    end
  end

  led_blink_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk         (sys_clk),
    .srst        (sys_rst),
    .en          (blink_en),
    .period      (period_reg),
    .clr_cnt     (wr_ctrl || wr_period),
    .clr_toggles (wr_status),
    .tick        (tick),
    .toggle_cnt  (toggle_cnt)
  );

  // LED driver: off when disabled, DIRECT in static mode, toggled on ticks.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led_test <= 1'b0;
    end else if (!ctrl_reg[CTRL_EN_BIT]) begin
      led_test <= 1'b0;
    end else if (!ctrl_reg[CTRL_MODE_BIT]) begin
      led_test <= direct_reg;
    end else if (tick) begin
      led_test <= !led_test;
    end
  end

endmodule

// File: tb/tb_led_mmio_slave.sv
// Directed testbench for led_mmio_slave with a response scoreboard.
module tb_led_mmio_slave;

  localparam int unsigned DEF_P = 25_000_000;

  logic        sys_clk   = 1'b0;
  logic        sys_rst   = 1'b1;
  logic        bus_valid = 1'b0;
  logic [3:0]  bus_addr  = 4'h0;
  logic [3:0]  bus_wstrb = 4'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        led_test;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic pre_led;
  logic resp_led;
  logic exp_led;
  logic p_led;
  exp_t e_b2b;

  always #5 sys_clk = ~sys_clk;

  led_mmio_slave #(
    .ADDR_W         (4),
    .DEFAULT_PERIOD (DEF_P),
    .CNT_W          (32)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .bus_valid (bus_valid),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err),
    .led_test  (led_test)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction: drive, expect bus_ready in the next cycle only.
  task automatic access(input string tag, input logic [3:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    exp_t e;
    pre_led   = led_test;
    bus_addr  = addr;
    bus_wstrb = strb;
    bus_wdata = wdata;
    bus_valid = 1'b1;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge sys_clk); #1;
    bus_valid = 1'b0;
    bus_wstrb = 4'h0;
    resp_led  = led_test;
    check({tag, " ready"}, 32'(bus_ready), 32'd1);
    e = exp_q.pop_front();
    check({tag, " err"}, 32'(bus_err), 32'(e.err));
    if (strb == 4'b0000 || exp_err) check({tag, " rdata"}, bus_rdata, e.rdata);
    $display("txn %s addr=%h wstrb=%b wdata=%h rdata=%h err=%b", tag, addr, strb, wdata,
             bus_rdata, bus_err);
    @(posedge sys_clk); #1;
    check({tag, " ready_drop"}, 32'(bus_ready), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst ready", 32'(bus_ready), 32'd0);
    check("rst rdata", bus_rdata, 32'd0);
    check("rst err", 32'(bus_err), 32'd0);
    check("rst led", 32'(led_test), 32'd0);
    sys_rst = 1'b0;

    // Reset register values
    access("rd_period_rst", 4'h4, 4'h0, 32'h0, DEF_P, 1'b0);
    access("rd_ctrl_rst",   4'h0, 4'h0, 32'h0, 32'h0, 1'b0);

    // Blink with PERIOD=3: LED toggles every third edge after the CTRL write
    access("wr_period3", 4'h4, 4'hF, 32'd3, 32'h0, 1'b0);
    access("wr_ctrl_blink", 4'h0, 4'hF, 32'h3, 32'h0, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      check($sformatf("blink3 led n=%0d", n), 32'(led_test), 32'((n / 3) % 2));
      if (n != 12) begin
        @(posedge sys_clk); #1;
      end
    end
    access("rd_status4", 4'h8, 4'h0, 32'h0, 32'h0004_0000, 1'b0);

    // Static mode and disable
    access("wr_direct1", 4'hC, 4'hF, 32'h1, 32'h0, 1'b0);
    access("rd_direct1", 4'hC, 4'h0, 32'h0, 32'h1, 1'b0);
    access("wr_ctrl_static", 4'h0, 4'hF, 32'h1, 32'h0, 1'b0);
    check("static led", 32'(led_test), 32'd1);
    access("wr_ctrl_off", 4'h0, 4'hF, 32'h0, 32'h0, 1'b0);
    check("off led", 32'(led_test), 32'd0);

    // Errors and byte strobes
    access("wr_unaligned", 4'h5, 4'hF, 32'h1234, 32'h0, 1'b1);
    access("rd_period_keep", 4'h4, 4'h0, 32'h0, 32'd3, 1'b0);
    access("rd_unaligned", 4'h2, 4'h0, 32'h0, 32'h0, 1'b1);
    access("wr_period_full", 4'h4, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
    access("wr_period_b0", 4'h4, 4'b0001, 32'hAABB_CCDD, 32'h0, 1'b0);
    access("rd_period_b0", 4'h4, 4'h0, 32'h0, 32'h1122_33DD, 1'b0);
    access("wr_period_b13", 4'h4, 4'b1010, 32'hAABB_CCDD, 32'h0, 1'b0);
    access("rd_period_b13", 4'h4, 4'h0, 32'h0, 32'hAA22_CCDD, 1'b0);

    // PERIOD=1: toggle every edge; STATUS clear coincides with a toggle
    access("wr_period1", 4'h4, 4'hF, 32'd1, 32'h0, 1'b0);
    access("wr_ctrl_blink1", 4'h0, 4'hF, 32'h3, 32'h0, 1'b0);
    access("wr_status_clr", 4'h8, 4'hF, 32'h0, 32'h0, 1'b0);
    exp_led = ~pre_led;
    check("clr_edge led toggled", 32'(resp_led), 32'(exp_led));
    p_led = pre_led;
    repeat (65534) @(posedge sys_clk);
    #1;
    access("rd_status_ffff", 4'h8, 4'h0, 32'h0, {16'hFFFF, 15'd0, p_led}, 1'b0);
    access("rd_status_wrap", 4'h8, 4'h0, 32'h0, {16'h0001, 15'd0, p_led}, 1'b0);

    // bus_valid held high: a response every second cycle
    bus_addr  = 4'h4;
    bus_wstrb = 4'h0;
    bus_valid = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back('{rdata: 32'd1, err: 1'b0});
    for (int k = 0; k < 8; k++) begin
      @(posedge sys_clk); #1;
      check($sformatf("b2b ready k=%0d", k), 32'(bus_ready), 32'((k % 2) == 0));
      if (bus_ready && exp_q.size() > 0) begin
        e_b2b = exp_q.pop_front();
        check($sformatf("b2b rdata k=%0d", k), bus_rdata, e_b2b.rdata);
        $display("txn b2b k=%0d rdata=%h err=%b", k, bus_rdata, bus_err);
      end
    end
    bus_valid = 1'b0;
    check("b2b queue drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Reset asserted during RESP drops the response and clears registers
    bus_addr  = 4'h0;
    bus_valid = 1'b1;
    @(posedge sys_clk); #1;
    bus_valid = 1'b0;
    check("rstresp ready_before", 32'(bus_ready), 32'd1);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    check("rstresp ready_after", 32'(bus_ready), 32'd0);
    check("rstresp led", 32'(led_test), 32'd0);
    sys_rst = 1'b0;
    access("rd_ctrl_postrst",   4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
    access("rd_period_postrst", 4'h4, 4'h0, 32'h0, DEF_P, 1'b0);
    access("rd_status_postrst", 4'h8, 4'h0, 32'h0, 32'h0, 1'b0);
    access("rd_direct_postrst", 4'hC, 4'h0, 32'h0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
